// File: rtl/pe_pkg.sv
// pe_pkg: shared width and depth constants for the PE and its buffer server
package pe_pkg;
  localparam int DEF_WIDTH        = 4;
  localparam int DEF_IFMAP_DEPTH  = 16;
  localparam int DEF_FILTER_DEPTH = 16;
  localparam int DEF_PSUM_DEPTH   = 32;
endpackage

// File: rtl/pe_stream_fifo.sv
// pe_stream_fifo: synchronous FIFO with flush, full/empty and show-ahead head word
module pe_stream_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign full  = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  // flush wins over push/pop; a full FIFO ignores pushes, an empty one ignores pops
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    wr_ptr_d = flush ? '0 : wr_ptr_q + PW'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PW'(do_pop);
    count_d  = flush ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  // storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/pe_buffer_server.sv
// pe_buffer_server: serves ifmap/filter/psum streams to one PE and captures its psum output
module pe_buffer_server
  import pe_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int IFMAP_DEPTH  = DEF_IFMAP_DEPTH,
  parameter int FILTER_DEPTH = DEF_FILTER_DEPTH,
  parameter int PSUM_DEPTH   = DEF_PSUM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_ifmap_wr,
  input  logic             host_filter_wr,
  input  logic             host_psum_wr,
  input  logic [WIDTH-1:0] host_ifmap_din,
  input  logic [WIDTH-1:0] host_filter_din,
  input  logic [WIDTH-1:0] host_psum_din,
  input  logic             host_ifmap_last,
  input  logic             host_clear,
  output logic             ifmap_full,
  output logic             filter_full,
  output logic             psum_in_full,
  input  logic             read_en_ifmap_buf,
  input  logic             read_en_filter_buf,
  input  logic             read_en_psum_buf,
  output logic             valid_ifmap,
  output logic             valid_filter,
  output logic             valid_psum_buf,
  output logic [WIDTH-1:0] inp_buf_ifmap,
  output logic [WIDTH-1:0] inp_buf_filter,
  output logic [WIDTH-1:0] inp_buf_psum,
  output logic             end_signal,
  input  logic             write_en_buf,
  input  logic [WIDTH-1:0] out_buf,
  input  logic             psum_out_pop,
  output logic [WIDTH-1:0] psum_out_dout,
  output logic             psum_out_empty,
  output logic             psum_overflow
);
  logic if_empty, fl_empty, ps_empty, po_full;
  logic [WIDTH-1:0] if_dout, fl_dout, ps_dout;
  logic pop_if, pop_fl, pop_ps;
  logic valid_if_q, valid_if_d, valid_fl_q, valid_fl_d, valid_ps_q, valid_ps_d;
  logic [WIDTH-1:0] data_if_q, data_if_d, data_fl_q, data_fl_d, data_ps_q, data_ps_d;
  logic last_seen_q, last_seen_d, end_q, end_d, ovf_q, ovf_d;

  pe_stream_fifo #(.WIDTH(WIDTH), .DEPTH(IFMAP_DEPTH)) u_ifmap (
    .clk(clk), .rst(rst), .flush(host_clear), .push(host_ifmap_wr), .pop(pop_if),
    .din(host_ifmap_din), .dout(if_dout), .full(ifmap_full), .empty(if_empty));
  pe_stream_fifo #(.WIDTH(WIDTH), .DEPTH(FILTER_DEPTH)) u_filter (
    .clk(clk), .rst(rst), .flush(host_clear), .push(host_filter_wr), .pop(pop_fl),
    .din(host_filter_din), .dout(fl_dout), .full(filter_full), .empty(fl_empty));
  pe_stream_fifo #(.WIDTH(WIDTH), .DEPTH(PSUM_DEPTH)) u_psum_in (
    .clk(clk), .rst(rst), .flush(host_clear), .push(host_psum_wr), .pop(pop_ps),
    .din(host_psum_din), .dout(ps_dout), .full(psum_in_full), .empty(ps_empty));
  pe_stream_fifo #(.WIDTH(WIDTH), .DEPTH(PSUM_DEPTH)) u_psum_out (
    .clk(clk), .rst(rst), .flush(1'b0), .push(write_en_buf), .pop(psum_out_pop),
    .din(out_buf), .dout(psum_out_dout), .full(po_full), .empty(psum_out_empty));

  assign valid_ifmap    = valid_if_q;
  assign valid_filter   = valid_fl_q;
  assign valid_psum_buf = valid_ps_q;
  assign inp_buf_ifmap  = data_if_q;
  assign inp_buf_filter = data_fl_q;
  assign inp_buf_psum   = data_ps_q;
  assign end_signal     = end_q;
  assign psum_overflow  = ovf_q;

  // responders pop on request with data present; end-of-data and overflow tracking
  always_comb begin
    pop_if      = read_en_ifmap_buf & ~if_empty & ~host_clear;
    pop_fl      = read_en_filter_buf & ~fl_empty & ~host_clear;
    pop_ps      = read_en_psum_buf & ~ps_empty & ~host_clear;
    valid_if_d  = pop_if;
    valid_fl_d  = pop_fl;
    valid_ps_d  = pop_ps;
    data_if_d   = pop_if ? if_dout : data_if_q;
    data_fl_d   = pop_fl ? fl_dout : data_fl_q;
    data_ps_d   = pop_ps ? ps_dout : data_ps_q;
    last_seen_d = ~host_clear & (last_seen_q | (host_ifmap_wr & host_ifmap_last & ~ifmap_full));
    end_d       = ~host_clear & (end_q | (last_seen_q & if_empty));
    ovf_d       = ovf_q | (write_en_buf & po_full);
  end

  // response, end and overflow registers
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_if_q  <= 1'b0;
      valid_fl_q  <= 1'b0;
      valid_ps_q  <= 1'b0;
      data_if_q   <= '0;
      data_fl_q   <= '0;
      data_ps_q   <= '0;
      last_seen_q <= 1'b0;
      end_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      valid_if_q  <= valid_if_d;
      valid_fl_q  <= valid_fl_d;
      valid_ps_q  <= valid_ps_d;
      data_if_q   <= data_if_d;
      data_fl_q   <= data_fl_d;
      data_ps_q   <= data_ps_d;
      last_seen_q <= last_seen_d;
      end_q       <= end_d;
      ovf_q       <= ovf_d;
    end
  end
endmodule
